// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry, synchronous flush and saturating stall counter.
// Latency: 1 cycle empty->out_valid. Backpressure: SKID=1 registers in_ready (low only while two entries held); SKID=0 passes out_ready through.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              xfer_in;
    logic              xfer_out;

    // With a skid entry, in_ready comes straight from a flop so upstream never sees out_ready combinationally.
    assign in_ready  = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        stall_cnt_d  = stall_cnt_q;

        if (SKID != 0) begin
            if (!out_valid_q) begin
                if (xfer_in) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                end
            end else if (!skid_valid_q) begin
                if (xfer_in && xfer_out) begin
                    out_data_d = in_data;
                end else if (xfer_in) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end else if (xfer_out) begin
                    out_valid_d = 1'b0;
                end
            end else if (xfer_out) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else begin
            if (xfer_in) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else if (xfer_out) begin
                out_valid_d = 1'b0;
            end
        end

        // Flush only kills the valid bits; data registers may keep stale contents.
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end

        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge resetl) begin
        if (resetl) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus, each checked against a queue-based model.
// Stimulus pushes accepted payloads; a negedge monitor pops on release and compares valid/ready/data/stall_cnt.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;
    localparam logic [DATA_W-1:0] BOOT_WORD = 96'h0000_0000_0000_0040_D503_201F;
    localparam logic [CNT_W-1:0]  CNT_MAX   = 4'hF;

    logic              clk;
    logic              resetl;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              in_ready_s1, out_valid_s1, in_ready_s0, out_valid_s0;
    logic [DATA_W-1:0] out_data_s1, out_data_s0;
    logic [CNT_W-1:0]  stall_s1, stall_s0;

    logic              in_rdy_a  [2];
    logic              out_vld_a [2];
    logic [DATA_W-1:0] out_dat_a [2];
    logic [CNT_W-1:0]  stall_a   [2];

    // Reference model: in-order queue of accepted payloads per instance.
    logic [DATA_W-1:0] sbq [2][$];
    logic              exp_rdy   [2];
    logic [CNT_W-1:0]  stall_exp [2];
    int                rel_cnt   [2];

    int n_checks;
    int n_fail;

    pipe_stage_reg #(.DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)) u_dut_s1 (
        .clk(clk), .resetl(resetl), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s1), .in_data(in_data),
        .out_valid(out_valid_s1), .out_ready(out_ready), .out_data(out_data_s1),
        .stall_cnt(stall_s1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .SKID(0), .CNT_W(CNT_W)) u_dut_s0 (
        .clk(clk), .resetl(resetl), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s0), .in_data(in_data),
        .out_valid(out_valid_s0), .out_ready(out_ready), .out_data(out_data_s0),
        .stall_cnt(stall_s0)
    );

    assign in_rdy_a[0]  = in_ready_s1;
    assign in_rdy_a[1]  = in_ready_s0;
    assign out_vld_a[0] = out_valid_s1;
    assign out_vld_a[1] = out_valid_s0;
    assign out_dat_a[0] = out_data_s1;
    assign out_dat_a[1] = out_data_s0;
    assign stall_a[0]   = stall_s1;
    assign stall_a[1]   = stall_s0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int id,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, id, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string nm, input int id, input logic act, input logic exp);
        check(nm, id, DATA_W'(act), DATA_W'(exp));
    endtask

    task automatic check_cnt(input string nm, input int id,
                             input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        check(nm, id, DATA_W'(act), DATA_W'(exp));
    endtask

    // Monitor: compares DUT against the model before each rising edge and retires released payloads.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!resetl) begin
                for (int i = 0; i < 2; i++) begin
                    int  sz;
                    logic exp_vld;
                    sz      = sbq[i].size();
                    exp_vld = (sz != 0);
                    exp_rdy[i] = (i == 0) ? (sz < 2) : ((sz == 0) || out_ready);
                    check_bit("out_valid", i, out_vld_a[i], exp_vld);
                    check_bit("in_ready", i, in_rdy_a[i], exp_rdy[i]);
                    check_cnt("stall_cnt", i, stall_a[i], stall_exp[i]);
                    if (exp_vld) check("out_data", i, out_dat_a[i], sbq[i][0]);
                    if (out_vld_a[i] && out_ready && sz != 0) begin
                        void'(sbq[i].pop_front());
                        rel_cnt[i]++;
                    end
                    if (exp_vld && !out_ready && stall_exp[i] != CNT_MAX) stall_exp[i]++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Advance one rising edge and record what each instance accepted or lost to flush.
    task automatic step();
        @(posedge clk);
        if (!resetl) begin
            for (int i = 0; i < 2; i++) begin
                if (flush) sbq[i].delete();
                else if (in_valid && exp_rdy[i]) sbq[i].push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            check_bit("rst_out_valid", i, out_vld_a[i], 1'b0);
            check("rst_out_data", i, out_dat_a[i], '0);
            check_cnt("rst_stall_cnt", i, stall_a[i], '0);
            check_bit("rst_in_ready", i, in_rdy_a[i], 1'b1);
        end
    endtask

    // Asynchronous pulse between edges; checked before any clock edge arrives.
    task automatic pulse_reset();
        #2 resetl = 1'b1;
        #1 check_reset_state();
        for (int i = 0; i < 2; i++) begin
            sbq[i].delete();
            stall_exp[i] = '0;
            exp_rdy[i]   = 1'b1;
        end
        #1 resetl = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i]   = 1'b1;
            stall_exp[i] = '0;
            rel_cnt[i]   = 0;
        end
        resetl = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) step();
        check_reset_state();
        resetl = 1'b0;
        step();

        // Fill to FULL, then reset mid-cycle and check single-cycle latency afterwards.
        drive(1'b1, 96'h11, 1'b0, 1'b0); step();
        drive(1'b1, 96'h22, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        sample();
        check_bit("full_in_ready", 0, in_ready_s1, 1'b0);
        check("full_out_data", 0, out_data_s1, 96'h11);
        check_bit("s0_full_in_ready", 1, in_ready_s0, 1'b0);
        step();
        pulse_reset();
        drive(1'b1, BOOT_WORD, 1'b1, 1'b0); step();
        drive(1'b0, '0, 1'b1, 1'b0);
        sample();
        check_bit("lat_out_valid", 0, out_valid_s1, 1'b1);
        check("lat_out_data", 0, out_data_s1, BOOT_WORD);
        check_bit("lat_out_valid", 1, out_valid_s0, 1'b1);
        check("lat_out_data", 1, out_data_s0, BOOT_WORD);
        step();

        // Skid fill and drain.
        drive(1'b1, 96'h11, 1'b0, 1'b0); step();
        drive(1'b1, 96'h22, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) step();
        sample();
        check_bit("drain_empty", 0, out_valid_s1, 1'b0);

        // Flush beats a simultaneous accept.
        drive(1'b1, 96'h11, 1'b0, 1'b0); step();
        drive(1'b1, 96'h22, 1'b0, 1'b0); step();
        drive(1'b1, 96'h33, 1'b0, 1'b1); step();
        drive(1'b0, '0, 1'b1, 1'b0);
        sample();
        check_bit("flush_out_valid", 0, out_valid_s1, 1'b0);
        check_bit("flush_in_ready", 0, in_ready_s1, 1'b1);
        check_bit("flush_out_valid", 1, out_valid_s0, 1'b0);
        repeat (3) step();

        // Streaming: 100 transfers back to back with no stalls.
        step();
        pulse_reset();
        rel_cnt[0] = 0;
        rel_cnt[1] = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, DATA_W'(k + 256), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        sample();
        for (int i = 0; i < 2; i++) begin
            check("stream_count", i, DATA_W'(rel_cnt[i]), DATA_W'(100));
            check_cnt("stream_stall", i, stall_a[i], '0);
        end

        // Saturation, flush leaves the count, reset clears it.
        drive(1'b1, 96'h55, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (20) step();
        sample();
        check_cnt("sat_stall", 0, stall_s1, CNT_MAX);
        check_cnt("sat_stall", 1, stall_s0, CNT_MAX);
        drive(1'b0, '0, 1'b0, 1'b1); step();
        drive(1'b0, '0, 1'b0, 1'b0); step();
        sample();
        check_cnt("flush_keeps_stall", 0, stall_s1, CNT_MAX);
        step();
        pulse_reset();

        // Randomised traffic with occasional flush and reset.
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom % 4) != 0, {$urandom(), $urandom(), $urandom()},
                  ($urandom % 3) != 0, ($urandom % 40) == 0);
            step();
            if ((k % 500) == 499) pulse_reset();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) step();
        sample();
        check_bit("final_empty", 0, out_valid_s1, 1'b0);
        check_bit("final_empty", 1, out_valid_s0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
